fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the synchronous FIFO (DEPTH entries, wr_en/rd_en interface) among NUM_REQ producers.
- Uses round-robin grants with bounded bursts.
- Tracks FIFO occupancy itself with a credit counter, so writes never depend on the FIFO's one-cycle-late registered full flag.
- Sits directly in front of the FIFO; the FIFO's consumer-side rd_en is fed back as fifo_pop.

Parameters:
- NUM_REQ, 4, number of producers (2..8)
- DEPTH, 16, FIFO depth; must match the FIFO instance
- DATA_W, 8, data word width
- MAX_BURST, 4, maximum beats per grant (1..DEPTH)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_valid  in  NUM_REQ  per-producer data valid
- req_data  in  NUM_REQ*DATA_W  producer i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  per-producer accept
- fifo_pop  in  1  FIFO consumer read strobe (same signal as FIFO rd_en)
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  DATA_W  FIFO write data
- grant_id  out  clog2(NUM_REQ)  current owner; valid while busy=1
- busy  out  1  a grant is held
- credits  out  clog2(DEPTH)+1  free FIFO entries
- pop_err  out  1  sticky: fifo_pop seen while credits==DEPTH

Reset and clocking:
- One clock; reset is asynchronous and active-low.
- Reset values: req_ready=0, fifo_wr_en=0, fifo_wr_data=0, grant_id=0, busy=0, credits=DEPTH, pop_err=0, rr pointer=NUM_REQ-1, state=IDLE, burst_cnt=0.

Behaviour:
- States: IDLE, BURST.
- IDLE:
  - If any req_valid is high, pick the first requester at or after (rr_ptr+1) mod NUM_REQ.
  - Register it into grant_id, set busy, clear burst_cnt, go to BURST next cycle (one-cycle arbitration bubble).
  - If no request, stay in IDLE.
- req_ready[i] = (state==BURST) && (grant_id==i) && (credits!=0). Decoded from registers only; no combinational path from req_valid.
- Beat: req_valid[g] && req_ready[g].
  - fifo_wr_en = beat (combinational, same cycle).
  - fifo_wr_data = req_data slice of grant_id when in BURST, else 0.
  - Data latency to FIFO = 0 cycles.
- BURST exit to IDLE next cycle (clear busy, rr_ptr <= grant_id) on either condition:
  - a beat with burst_cnt==MAX_BURST-1, or
  - req_valid[grant_id]==0 in any cycle, including while credits==0.
- Otherwise, a beat increments burst_cnt.
- credits==0 with req_valid[g]=1: grant is held, ready stays low, no timeout.
- Credit update: credits_next = credits - beat + pop_eff, where pop_eff = fifo_pop && credits!=DEPTH.
  - Write and pop in the same cycle: unchanged.
  - Pop at credits==0: no beat that cycle (ready was 0), credits becomes 1.
  - Pop at credits==DEPTH: ignored; pop_err set and held until reset.
- credits never exceeds DEPTH and never goes below 0.
- Non-granted producers always see ready=0. Their valid may assert or deassert freely.
- Reset mid-burst: all state returns to reset values immediately (asynchronously). Any beat in that cycle is lost. The FIFO is reset by the same rst_n.
- NUM_REQ==1: arbitration still costs one IDLE cycle per burst.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, BURST}
  - localparams for credit width clog2(DEPTH)+1, id width clog2(NUM_REQ), burst-count width clog2(MAX_BURST)+1.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req vector, last pointer.
  - Outputs: any, idx.
  - Reusable by the read-side scheduler later.

Test Plan:
- Reset release, all valid=0 for 10 cycles -> busy=0, fifo_wr_en=0, credits=16, req_ready=0000.
- req_valid=1111 continuously, no pops -> grants in order 0,1,2,3, 4 beats each.
  - 1 idle cycle between bursts.
  - Credits 16->0 after the 16th beat.
  - After that, grant 0 is held with ready=0 and fifo_wr_en=0.
- From the full state: pop once -> credits=1, exactly one beat next cycle, credits back to 0. FIFO full asserts and no FIFO overflow occurs.
- Producer 2 alone, valid for 2 cycles then low, data 8'hA1, 8'hA2:
  - both beats written in order;
  - grant released the cycle after valid drops;
  - rr_ptr=2, so a subsequent request 1111 grants 3 first.
- Simultaneous beat and pop at credits=5 -> credits stays 5. Pop with credits=16 -> credits stays 16, pop_err=1 and remains 1.
- rst_n pulled low mid-burst (grant 1, burst_cnt=2) -> same-instant busy=0, ready=0, credits=16. After release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types, default parameters and width helpers for the
// FIFO write-port arbiter and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Default configuration of fifo_wr_arbiter.
  localparam int unsigned NumReqDef   = 4;
  localparam int unsigned DepthDef    = 16;
  localparam int unsigned DataWDef    = 8;
  localparam int unsigned MaxBurstDef = 4;

  // Credit counter must hold 0..DEPTH inclusive, hence the extra bit.
  function automatic int unsigned cred_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Keep ids at least one bit wide so a single-producer build still elaborates.
  function automatic int unsigned id_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int unsigned burst_width(input int unsigned max_burst);
    return $clog2(max_burst) + 1;
  endfunction

  localparam int unsigned CredWDef  = cred_width(DepthDef);
  localparam int unsigned IdWDef    = id_width(NumReqDef);
  localparam int unsigned BurstWDef = burst_width(MaxBurstDef);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Returns the first set bit of req at or after (last+1) mod N.
//   req  - request vector
//   last - index granted most recently
//   any  - at least one request is set
//   idx  - selected index (equals last when any=0)
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = last;
    cand = last;
    // Walk the ring starting one past last; last itself is visited at k == N.
    for (int k = 1; k <= int'(N); k++) begin
      cand = IW'((int'(last) + k) % int'(N));
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the single write port of a synchronous FIFO among
// NUM_REQ producers with round-robin grants and bursts of at most MAX_BURST
// beats. FIFO occupancy is tracked locally with a credit counter so writes
// never depend on the FIFO's registered full flag.
//   clk, rst_n    - clock, asynchronous active-low reset
//   req_valid     - per-producer data valid
//   req_data      - producer i data at [i*DATA_W +: DATA_W]
//   req_ready     - per-producer accept (owner only, credits permitting)
//   fifo_pop      - FIFO consumer read strobe (the FIFO's rd_en)
//   fifo_wr_en    - FIFO write strobe
//   fifo_wr_data  - FIFO write data
//   grant_id      - current owner, meaningful while busy
//   busy          - a grant is held
//   credits       - free FIFO entries
//   pop_err       - sticky: pop seen while the FIFO was empty
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NumReqDef,
  parameter int unsigned DEPTH     = DepthDef,
  parameter int unsigned DATA_W    = DataWDef,
  parameter int unsigned MAX_BURST = MaxBurstDef,
  localparam int unsigned IdW      = id_width(NUM_REQ),
  localparam int unsigned CredW    = cred_width(DEPTH),
  localparam int unsigned BurstW   = burst_width(MAX_BURST)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_pop,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic [IdW-1:0]            grant_id,
  output logic                      busy,
  output logic [CredW-1:0]          credits,
  output logic                      pop_err
);

  arb_state_e        state_q;
  logic [IdW-1:0]    grant_q;
  logic [IdW-1:0]    rr_q;
  logic              busy_q;
  logic              pop_err_q;
  logic [CredW-1:0]  credits_q;
  logic [CredW-1:0]  credits_d;
  logic [BurstW-1:0] burst_q;

  logic           pick_any;
  logic [IdW-1:0] pick_idx;
  logic           has_credit;
  logic           grant_valid;
  logic           beat;
  logic           pop_eff;
  logic           last_beat;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IdW)
  ) u_rr_pick (
    .req  (req_valid),
    .last (rr_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Ready and write data are decoded from registered state only; req_valid
  // reaches fifo_wr_en but never req_ready.
  always_comb begin
    has_credit   = (credits_q != '0);
    grant_valid  = req_valid[grant_q];
    req_ready    = '0;
    fifo_wr_data = '0;
    if (state_q == BURST) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (grant_q == IdW'(i)) begin
          req_ready[i] = has_credit;
          fifo_wr_data = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
    beat      = (state_q == BURST) && has_credit && grant_valid;
    // A pop against an already-empty FIFO returns no credit.
    pop_eff   = fifo_pop && (credits_q != CredW'(DEPTH));
    last_beat = beat && (burst_q == BurstW'(MAX_BURST - 1));

    credits_d = credits_q;
    if (beat && !pop_eff) begin
      credits_d = credits_q - CredW'(1);
    end else if (!beat && pop_eff) begin
      credits_d = credits_q + CredW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= IdW'(NUM_REQ - 1);
      busy_q    <= 1'b0;
      burst_q   <= '0;
      credits_q <= CredW'(DEPTH);
      pop_err_q <= 1'b0;
    end else begin
      credits_q <= credits_d;
      if (fifo_pop && !pop_eff) begin
        pop_err_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            busy_q  <= 1'b1;
            burst_q <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          // Owner dropping valid releases the grant even while starved of credit.
          if (!grant_valid || last_beat) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            rr_q    <= grant_q;
          end else if (beat) begin
            burst_q <= burst_q + BurstW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_wr_en = beat;
  assign grant_id   = grant_q;
  assign busy       = busy_q;
  assign credits    = credits_q;
  assign pop_err    = pop_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed, table-driven bench for fifo_wr_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units
// later, well away from either clock edge.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int unsigned NR = NumReqDef;
  localparam int unsigned DW = DataWDef;

  typedef struct {
    logic [NR-1:0]       valid;
    logic [NR*DW-1:0]    data;
    logic                pop;
    logic [NR-1:0]       ready;
    logic                wr_en;
    logic [DW-1:0]       wr_data;
    logic                busy;
    logic [IdWDef-1:0]   grant;
    logic [CredWDef-1:0] credits;
  } vec_t;

  logic                clk;
  logic                rst_n;
  logic [NR-1:0]       req_valid;
  logic [NR*DW-1:0]    req_data;
  logic [NR-1:0]       req_ready;
  logic                fifo_pop;
  logic                fifo_wr_en;
  logic [DW-1:0]       fifo_wr_data;
  logic [IdWDef-1:0]   grant_id;
  logic                busy;
  logic [CredWDef-1:0] credits;
  logic                pop_err;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt;
  int pop_cnt;

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DEPTH     (DepthDef),
    .DATA_W    (DW),
    .MAX_BURST (MaxBurstDef)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_pop     (fifo_pop),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
    .busy         (busy),
    .credits      (credits),
    .pop_err      (pop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts of FIFO writes and pops since the last reset, for an overflow check.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= 0;
      pop_cnt <= 0;
    end else begin
      wr_cnt  <= wr_cnt + (fifo_wr_en ? 1 : 0);
      pop_cnt <= pop_cnt + (fifo_pop ? 1 : 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    req_valid = v.valid;
    req_data  = v.data;
    fifo_pop  = v.pop;
    #2;
    chk({tag, ".ready"},   32'(req_ready),    32'(v.ready));
    chk({tag, ".wr_en"},   32'(fifo_wr_en),   32'(v.wr_en));
    chk({tag, ".wr_data"}, 32'(fifo_wr_data), 32'(v.wr_data));
    chk({tag, ".busy"},    32'(busy),         32'(v.busy));
    chk({tag, ".credits"}, 32'(credits),      32'(v.credits));
    if (v.busy) chk({tag, ".grant"}, 32'(grant_id), 32'(v.grant));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_pop  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl [14];
  vec_t v;
  int   beats;

  localparam logic [31:0] DataD = 32'hD3D2_D1D0;

  initial begin
    // valid, data, pop | ready, wr_en, wr_data, busy, grant, credits
    tbl[0]  = '{4'b0100, 32'h00A1_0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 5'd16};
    tbl[1]  = '{4'b0100, 32'h00A1_0000, 1'b0, 4'b0100, 1'b1, 8'hA1, 1'b1, 2'd2, 5'd16};
    tbl[2]  = '{4'b0100, 32'h00A2_0000, 1'b0, 4'b0100, 1'b1, 8'hA2, 1'b1, 2'd2, 5'd15};
    tbl[3]  = '{4'b0000, 32'h00A2_0000, 1'b0, 4'b0100, 1'b0, 8'hA2, 1'b1, 2'd2, 5'd14};
    tbl[4]  = '{4'b1111, 32'h3322_1155, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 5'd14};
    tbl[5]  = '{4'b1111, 32'h3322_1155, 1'b0, 4'b1000, 1'b1, 8'h33, 1'b1, 2'd3, 5'd14};
    tbl[6]  = '{4'b1111, 32'h3322_1155, 1'b0, 4'b1000, 1'b1, 8'h33, 1'b1, 2'd3, 5'd13};
    tbl[7]  = '{4'b1111, 32'h3322_1155, 1'b0, 4'b1000, 1'b1, 8'h33, 1'b1, 2'd3, 5'd12};
    tbl[8]  = '{4'b1111, 32'h3322_1155, 1'b0, 4'b1000, 1'b1, 8'h33, 1'b1, 2'd3, 5'd11};
    tbl[9]  = '{4'b1111, 32'h3322_1155, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 5'd10};
    tbl[10] = '{4'b1111, 32'h3322_1155, 1'b0, 4'b0001, 1'b1, 8'h55, 1'b1, 2'd0, 5'd10};
    tbl[11] = '{4'b0000, 32'h3322_1155, 1'b0, 4'b0001, 1'b0, 8'h55, 1'b1, 2'd0, 5'd9};
    tbl[12] = '{4'b0000, 32'h3322_1155, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 5'd9};
    tbl[13] = '{4'b0000, 32'h3322_1155, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 5'd10};

    // Reset state held for 10 idle cycles.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply('{4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 5'd16}, "reset_idle");
    end
    chk("reset.pop_err", 32'(pop_err), 32'd0);

    // Producer 2 short burst, release, then rr pointer favours producer 3.
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
    end

    // All producers valid, no pops: four full bursts, then starved on credit.
    do_reset();
    beats = 0;
    for (int c = 0; c < 25; c++) begin
      v.valid = 4'b1111;
      v.data  = DataD;
      v.pop   = 1'b0;
      if (c < 20 && (c % 5) != 0) begin
        v.ready   = 4'(1 << (c / 5));
        v.wr_en   = 1'b1;
        v.wr_data = 8'(8'hD0 + (c / 5));
        v.busy    = 1'b1;
        v.grant   = 2'(c / 5);
      end else if (c >= 21) begin
        v.ready   = 4'b0000;
        v.wr_en   = 1'b0;
        v.wr_data = 8'hD0;
        v.busy    = 1'b1;
        v.grant   = 2'd0;
      end else begin
        v.ready   = 4'b0000;
        v.wr_en   = 1'b0;
        v.wr_data = 8'h00;
        v.busy    = 1'b0;
        v.grant   = 2'd0;
      end
      v.credits = 5'(16 - beats);
      apply(v, $sformatf("fill%0d", c));
      if (v.wr_en) beats++;
    end

    // One pop from full buys exactly one beat.
    apply('{4'b1111, DataD, 1'b1, 4'b0000, 1'b0, 8'hD0, 1'b1, 2'd0, 5'd0}, "pop_full");
    apply('{4'b1111, DataD, 1'b0, 4'b0001, 1'b1, 8'hD0, 1'b1, 2'd0, 5'd1}, "refill");
    apply('{4'b1111, DataD, 1'b0, 4'b0000, 1'b0, 8'hD0, 1'b1, 2'd0, 5'd0}, "full_again");
    chk("no_overflow", 32'(wr_cnt - pop_cnt), 32'd16);

    // Drop valid while starved: grant released; drain to 5 credits.
    apply('{4'b0000, DataD, 1'b0, 4'b0000, 1'b0, 8'hD0, 1'b1, 2'd0, 5'd0}, "release_starved");
    for (int k = 0; k < 5; k++) begin
      apply('{4'b0000, DataD, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 5'(k)}, "drain");
    end
    apply('{4'b0001, DataD, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 5'd5}, "arb_c");
    apply('{4'b0001, DataD, 1'b1, 4'b0001, 1'b1, 8'hD0, 1'b1, 2'd0, 5'd5}, "beat_pop");
    apply('{4'b0000, DataD, 1'b0, 4'b0001, 1'b0, 8'hD0, 1'b1, 2'd0, 5'd5}, "cred_same");

    // Pop against an empty FIFO.
    do_reset();
    chk("pop_err.before", 32'(pop_err), 32'd0);
    apply('{4'b0000, 32'h0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 5'd16}, "pop_empty");
    chk("pop_err.set", 32'(pop_err), 32'd1);
    apply('{4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 5'd16}, "pop_empty_after");
    apply('{4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 5'd16}, "pop_empty_after");
    chk("pop_err.sticky", 32'(pop_err), 32'd1);

    // Asynchronous reset in the middle of a producer-1 burst (burst_cnt=2).
    do_reset();
    apply('{4'b0010, 32'h0000_B100, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 5'd16}, "d_arb");
    apply('{4'b0010, 32'h0000_B100, 1'b0, 4'b0010, 1'b1, 8'hB1, 1'b1, 2'd1, 5'd16}, "d_b0");
    apply('{4'b0010, 32'h0000_B100, 1'b0, 4'b0010, 1'b1, 8'hB1, 1'b1, 2'd1, 5'd15}, "d_b1");
    chk("d_pre.busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("d_rst.busy",    32'(busy),       32'd0);
    chk("d_rst.ready",   32'(req_ready),  32'd0);
    chk("d_rst.credits", 32'(credits),    32'd16);
    chk("d_rst.wr_en",   32'(fifo_wr_en), 32'd0);
    #2;
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    req_data  = DataD;
    @(posedge clk);
    #1;
    apply('{4'b1111, DataD, 1'b0, 4'b0001, 1'b1, 8'hD0, 1'b1, 2'd0, 5'd16}, "d_restart");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
